polylut_add_stream_ctrl: RTL and testbench

- Streaming controller at both ends of the free-running, stall-free polylut_add inference pipeline.
- Accepts feature vectors on a ready/valid slave port and drives them onto the pipeline input.
- Tracks each accepted sample through the fixed pipeline latency with a valid tag, captures the class scores and computes the argmax class.
- Buffers results in a FIFO toward a ready/valid master port. Credit-based admission guarantees no result is lost under downstream backpressure.

---
 rtl/polylut_add_stream_ctrl_if.sv | 17 +
 rtl/polylut_add_stream_ctrl.sv | 70 +++++++
 tb/tb_polylut_add_stream_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/polylut_add_stream_ctrl_if.sv
// polylut_add_stream_ctrl_if: feature-vector input stream and classified-result output stream
interface polylut_add_stream_ctrl_if #(
  parameter int IN_W = 112,
  parameter int N_CLS = 5,
  parameter int CLS_W = 5,
  parameter int CLS_IW = (N_CLS > 1) ? $clog2(N_CLS) : 1
);
  logic s_valid;
  logic s_ready;
  logic [IN_W-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic [N_CLS*CLS_W-1:0] m_scores;
  logic [CLS_IW-1:0] m_class;
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, m_scores, m_class);
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_scores, m_class);
endinterface

// File: rtl/polylut_add_stream_ctrl.sv
// polylut_add_stream_ctrl: credit-admitted tag tracking, argmax capture and result FIFO around a stall-free pipeline
module polylut_add_stream_ctrl #(
  parameter int IN_W = 112,
  parameter int N_CLS = 5,
  parameter int CLS_W = 5,
  parameter int PIPE_LAT = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int SCORE_SIGNED = 1
) (
  input logic clk,
  input logic rst,
  polylut_add_stream_ctrl_if.slave bus,
  output logic [IN_W-1:0] pipe_in,
  input logic [N_CLS*CLS_W-1:0] pipe_out,
  output logic err_ovf
);
  localparam int SW = N_CLS * CLS_W;
  localparam int CW = (N_CLS > 1) ? $clog2(N_CLS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  logic [PIPE_LAT-1:0] tag;
  logic [CW+SW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [OW-1:0] occ;
  logic accept, pop, cap, full, wr;
  logic [CW-1:0] best;
  logic [CLS_W-1:0] bv;
  function automatic logic gt(input logic [CLS_W-1:0] a, input logic [CLS_W-1:0] b);
    return (SCORE_SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
  endfunction
  // strict greater-than keeps the lowest index on ties
  always_comb begin
    best = '0;
    bv = pipe_out[CLS_W-1:0];
    for (int i = 1; i < N_CLS; i++)
      if (gt(pipe_out[CLS_W*i +: CLS_W], bv)) begin
        best = CW'(i);
        bv = pipe_out[CLS_W*i +: CLS_W];
      end
  end
  assign pipe_in = bus.s_data;
  assign bus.s_ready = rst & (occ < OW'(FIFO_DEPTH));
  assign accept = bus.s_valid & bus.s_ready;
  assign cap = tag[PIPE_LAT-1];
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign wr = cap & ~full;
  assign bus.m_valid = cnt != '0;
  assign pop = bus.m_valid & bus.m_ready;
  assign {bus.m_class, bus.m_scores} = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {best, pipe_out};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      occ <= '0;
      err_ovf <= 1'b0;
    end else begin
      tag <= PIPE_LAT'({tag, accept});
      wp <= wr ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      occ <= occ + OW'(accept) - OW'(pop);
      err_ovf <= err_ovf | (cap & full) | (pop & (occ == '0));
    end
  end
endmodule

// File: tb/tb_polylut_add_stream_ctrl.sv
// tb_polylut_add_stream_ctrl: three controllers (depth 16 signed, depth 4 signed, depth 16 unsigned) on a shared stimulus,
// each checked by a result-queue scoreboard fed from its own handshakes.
module tb_polylut_add_stream_ctrl;
  localparam int NG = 3;
  localparam int PL = 10;
  typedef struct {
    logic [24:0] sc;
    int cls;
    int due;
  } res_t;
  logic clk = 1'b0;
  logic rst;
  logic sv;
  logic [111:0] sd;
  logic mr [NG];
  logic s_ready [NG];
  logic m_valid [NG];
  logic err [NG];
  logic [24:0] m_scores [NG];
  logic [2:0] m_class [NG];
  logic [111:0] pin [NG];
  logic [24:0] pout [NG];
  logic [24:0] dl [NG][PL];
  res_t q [NG][$];
  int cyc = 0;
  int passed = 0;
  int total = 0;
  int acc_n [NG] = '{default: 0};
  int pop_n [NG] = '{default: 0};
  always #5 clk = ~clk;

  for (genvar g = 0; g < NG; g++) begin : u
    polylut_add_stream_ctrl_if #(.IN_W(112), .N_CLS(5), .CLS_W(5)) bus ();
    polylut_add_stream_ctrl #(
      .IN_W(112), .N_CLS(5), .CLS_W(5), .PIPE_LAT(PL),
      .FIFO_DEPTH(g == 1 ? 4 : 16), .SCORE_SIGNED(g == 2 ? 0 : 1)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus), .pipe_in(pin[g]), .pipe_out(pout[g]), .err_ovf(err[g])
    );
    assign bus.s_valid = sv;
    assign bus.s_data = sd;
    assign bus.m_ready = mr[g];
    assign s_ready[g] = bus.s_ready;
    assign m_valid[g] = bus.m_valid;
    assign m_scores[g] = bus.m_scores;
    assign m_class[g] = bus.m_class;
    assign pout[g] = dl[g][PL-1];
  end

  // the inference pipeline is modelled as a pure PL-stage delay of the low score bits
  always @(posedge clk)
    for (int i = 0; i < NG; i++) begin
      dl[i][0] <= pin[i][24:0];
      for (int k = 1; k < PL; k++) dl[i][k] <= dl[i][k-1];
    end

  function automatic int depth(input int g);
    return (g == 1) ? 4 : 16;
  endfunction

  function automatic int ref_cls(input logic [24:0] sc, input bit sgn);
    int best = 0;
    int bv = -100;
    int v;
    for (int i = 0; i < 5; i++) begin
      v = int'(sc[5*i +: 5]);
      if (sgn && v > 15) v -= 32;
      if (v > bv) begin
        bv = v;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [111:0] rnd_data();
    logic [111:0] d = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 5; i++)
      if ($urandom_range(0, 1) == 1) d[5*i +: 5] = 5'($urandom_range(0, 2));
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard: push on accept, pop and compare on each output handshake
  always @(posedge clk) begin
    for (int i = 0; i < NG; i++) begin
      if (!rst) q[i].delete();
      else begin
        if (m_valid[i] && mr[i] && q[i].size() > 0) begin
          chk($sformatf("pop_scores[%0d]", i), 32'(m_scores[i]), 32'(q[i][0].sc));
          chk($sformatf("pop_class[%0d]", i), 32'(m_class[i]), 32'(q[i][0].cls));
          void'(q[i].pop_front());
          pop_n[i] <= pop_n[i] + 1;
        end
        if (sv && s_ready[i]) begin
          q[i].push_back('{sc: sd[24:0], cls: ref_cls(sd[24:0], i != 2), due: cyc + 1 + PL});
          acc_n[i] <= acc_n[i] + 1;
        end
      end
    end
    cyc <= cyc + 1;
  end

  // a result must be visible exactly from its due cycle; credits equal model results outstanding
  always @(negedge clk)
    for (int i = 0; i < NG; i++) begin
      chk($sformatf("m_valid[%0d]", i), 32'(m_valid[i]),
          32'(rst && q[i].size() > 0 && cyc >= q[i][0].due));
      chk($sformatf("s_ready[%0d]", i), 32'(s_ready[i]), 32'(rst && q[i].size() < depth(i)));
      chk($sformatf("err_ovf[%0d]", i), 32'(err[i]), 0);
    end

  initial begin
    int a0, a2, p0, p2, drops;
    int pp [NG];
    logic [111:0] h;
    sv = 1'b1;
    sd = '0;
    for (int i = 0; i < NG; i++) mr[i] = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    step(3);
    @(negedge clk);
    for (int i = 0; i < NG; i++) begin
      chk("rst_s_ready", 32'(s_ready[i]), 0);
      chk("rst_m_valid", 32'(m_valid[i]), 0);
      chk("rst_err", 32'(err[i]), 0);
    end
    @(posedge clk);
    #1;
    sv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NG; i++) chk("ready_after_rst", 32'(s_ready[i]), 1);
    step(30);
    // single sample with a c1/c2 tie
    for (int i = 0; i < NG; i++) mr[i] = 1'b1;
    sd = rnd_data();
    sd[24:0] = {5'h03, 5'h1E, 5'h07, 5'h07, 5'h00};
    sv = 1'b1;
    step(1);
    sv = 1'b0;
    step(9);
    @(negedge clk);
    chk("single_early", 32'(m_valid[0]), 0);
    step(1);
    @(negedge clk);
    chk("single_valid", 32'(m_valid[0]), 1);
    chk("single_scores", 32'(m_scores[0]), 32'(25'h3F1CE0));
    chk("single_class", 32'(m_class[0]), 1);
    step(5);
    // back-to-back stream
    a0 = acc_n[0];
    a2 = acc_n[2];
    p0 = pop_n[0];
    p2 = pop_n[2];
    drops = 0;
    sv = 1'b1;
    repeat (20) begin
      sd = rnd_data();
      step(1);
      if (!s_ready[0] || !s_ready[2]) drops++;
    end
    sv = 1'b0;
    chk("stream_ready_drops", 32'(drops), 0);
    chk("stream_accepts0", 32'(acc_n[0] - a0), 20);
    chk("stream_accepts2", 32'(acc_n[2] - a2), 20);
    step(15);
    chk("stream_pops0", 32'(pop_n[0] - p0), 20);
    chk("stream_pops2", 32'(pop_n[2] - p2), 20);
    // backpressure on the depth-4 controller
    for (int i = 0; i < NG; i++) mr[i] = 1'b0;
    a0 = acc_n[1];
    h = rnd_data();
    sd = h;
    sv = 1'b1;
    step(1);
    repeat (7) begin
      sd = rnd_data();
      step(1);
    end
    sv = 1'b0;
    chk("bp_accepts", 32'(acc_n[1] - a0), 4);
    chk("bp_s_ready", 32'(s_ready[1]), 0);
    step(12);
    chk("bp_head_valid", 32'(m_valid[1]), 1);
    chk("bp_head_scores", 32'(m_scores[1]), 32'(h[24:0]));
    for (int i = 0; i < NG; i++) mr[i] = 1'b1;
    p0 = pop_n[1];
    step(1);
    @(negedge clk);
    chk("bp_ready_after_pop", 32'(s_ready[1]), 1);
    step(5);
    chk("bp_pops", 32'(pop_n[1] - p0), 4);
    chk("bp_err", 32'(err[1]), 0);
    step(10);
    // signed vs unsigned argmax
    sd = rnd_data();
    sd[24:0] = {5'h0F, 5'h10, 5'h10, 5'h10, 5'h10};
    sv = 1'b1;
    step(1);
    sv = 1'b0;
    step(10);
    @(negedge clk);
    chk("signed_class", 32'(m_class[0]), 4);
    chk("unsigned_class", 32'(m_class[2]), 0);
    step(2);
    // reset with results both in flight and buffered
    for (int i = 0; i < NG; i++) mr[i] = 1'b0;
    sv = 1'b1;
    sd = rnd_data();
    step(2);
    sv = 1'b0;
    step(8);
    sv = 1'b1;
    repeat (3) begin
      sd = rnd_data();
      step(1);
    end
    sv = 1'b0;
    chk("mid_buffered", 32'(m_valid[0]), 1);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NG; i++) begin
      chk("mid_rst_m_valid", 32'(m_valid[i]), 0);
      chk("mid_rst_s_ready", 32'(s_ready[i]), 0);
    end
    step(1);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NG; i++) begin
      chk("mid_ready_after_rst", 32'(s_ready[i]), 1);
      mr[i] = 1'b1;
      pp[i] = pop_n[i];
    end
    step(15);
    for (int i = 0; i < NG; i++) chk("mid_no_stale", 32'(pop_n[i] - pp[i]), 0);
    // random traffic and backpressure
    repeat (600) begin
      sv = ($urandom_range(0, 3) != 0);
      sd = rnd_data();
      for (int i = 0; i < NG; i++) mr[i] = ($urandom_range(0, 2) != 0);
      step(1);
    end
    sv = 1'b0;
    for (int i = 0; i < NG; i++) mr[i] = 1'b1;
    step(30);
    for (int i = 0; i < NG; i++) chk("drained", 32'(q[i].size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
